arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 16: data bits per channel.
REQ-002 Parameter N, default 4: number of input channels, legal range 2..16.
REQ-003 Parameter MODE, default 1: 0 = fixed priority, 1 = round-robin, 2 = direct select via sel.
REQ-004 Derived SELW = max(1, ceil(log2 N)), used as the index width.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1: reset; synchronous, active-low.
REQ-007 Port in_data, input, N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port in_valid, input, N: channel i offers a word.
REQ-009 Port in_ready, output, N: channel i word is accepted this cycle.
REQ-010 Port sel, input, SELW: channel index, used only when MODE=2.
REQ-011 Port out_data, output, WIDTH: registered selected word.
REQ-012 Port out_valid, output, 1: out_data holds an undelivered word.
REQ-013 Port out_ready, input, 1: consumer accepts out_data this cycle.
REQ-014 Port out_grant, output, SELW: index of the channel whose word is in out_data.

Function
REQ-015 A transfer on channel i occurs when in_valid[i] and in_ready[i] are both 1 at a clock edge; output delivery occurs when out_valid and out_ready are both 1.
REQ-016 Load enable: load = !out_valid || out_ready; in_ready is all-zero whenever load = 0.
REQ-017 At most one in_ready bit is 1 in any cycle, and only for a channel with in_valid = 1 (one-hot or zero).
REQ-018 in_ready is combinational from in_valid, sel, pointer state, out_valid and out_ready; no input data feeds it.
REQ-019 MODE=0: the lowest-index valid channel is granted.
REQ-020 MODE=1: the search starts at ptr and wraps modulo N; the first valid channel is granted.
REQ-021 MODE=1: ptr updates to (granted index + 1) mod N only on a transfer; with no transfer, ptr holds.
REQ-022 MODE=2: channel sel is granted iff in_valid[sel]; other channels are never ready.
REQ-023 MODE=2: a sel value of N or greater grants nothing.
REQ-024 On a transfer, out_data <= granted word, out_grant <= granted index, out_valid <= 1 at the same edge (latency 1 cycle).
REQ-025 On a delivery with no transfer in the same cycle, out_valid <= 0; out_data and out_grant hold.
REQ-026 Simultaneous delivery and transfer: the new word replaces the old one with no bubble, giving a sustained throughput of 1 word per cycle.
REQ-027 While out_valid = 1 and out_ready = 0, out_data, out_grant and out_valid are held stable.
REQ-028 An input deasserting in_valid without a transfer is permitted; the block does not latch requests.

Reset
REQ-029 When rst_n = 0 at an edge: out_valid <= 0, out_data <= 0, out_grant <= 0, ptr <= 0.
REQ-030 While rst_n = 0, in_ready is forced to all-zero regardless of inputs.
REQ-031 Reset mid-transfer discards any held word; no transfer is counted in that cycle.
REQ-032 Normal operation resumes on the first edge at which rst_n = 1.

Verification
REQ-033 MODE=1, N=4, all in_valid = 1, out_ready = 1, distinct data 0xA0..0xA3 -> out_grant sequence 0,1,2,3,0,..., with out_valid = 1 every cycle after the first.
REQ-034 MODE=0, in_valid = 4'b1010, out_ready = 1 -> channel 1 is granted every cycle; in_ready = 4'b0010; channel 3 is never granted.
REQ-035 MODE=1, out_valid = 1 with out_ready held 0 for 3 cycles -> in_ready = 0, out_data and out_grant stable; ptr unchanged; on release the next grant continues rotation.
REQ-036 MODE=2, sel = 2, in_valid = 4'b0100, in_data[2] = 0x1234 -> out_data = 0x1234 and out_grant = 2 one cycle later; with sel = 2 and in_valid = 4'b1011, no grant occurs.
REQ-037 Assert rst_n = 0 for one cycle while out_valid = 1 and inputs are valid -> next cycle out_valid = 0, out_data = 0, in_ready = 0 during reset, and the first grant after reset is the lowest valid index.
REQ-038 Random valid/ready stimulus with a scoreboard -> every accepted word is delivered exactly once, in order, with the correct out_grant; in_ready is never multi-hot.

Source files
------------

// File: rtl/arb_mux.sv
// arb_mux: N-channel arbiter (fixed priority, round-robin or direct select) feeding one registered output slot.
// Latency: one cycle from an input transfer to out_valid/out_data/out_grant.
// Backpressure: in_ready only while the slot is empty or draining this cycle; sustains 1 word/cycle when out_ready stays high.
module arb_mux #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int MODE  = 1,
  localparam int SELW = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_grant
);

  localparam int CW = SELW + 1;

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  ptr_next;
  logic [SELW-1:0]  grant_idx;
  logic             grant_vld;
  logic [WIDTH-1:0] grant_word;
  logic [CW-1:0]    cand;
  logic             load;
  logic             xfer;
  logic             unused_ok;

  // sel only matters for direct select, ptr only for round-robin
  assign unused_ok = ^{sel, ptr, cand};

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (MODE == 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end else if (MODE == 1) begin
      // walk backwards so the candidate closest to ptr is assigned last and wins
      for (int k = N - 1; k >= 0; k--) begin
        cand = CW'(ptr) + CW'(k);
        if (cand >= CW'(N)) cand = cand - CW'(N);
        if (in_valid[cand[SELW-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = cand[SELW-1:0];
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end
  end

  always_comb begin
    grant_word = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) grant_word = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign load = !out_valid || out_ready;

  always_comb begin
    in_ready = '0;
    if (rst_n && load && grant_vld) in_ready[grant_idx] = 1'b1;
  end

  assign xfer     = |in_ready;
  assign ptr_next = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_grant <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_word;
        out_grant <= grant_idx;
        if (MODE == 1) ptr <= ptr_next;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: one instance per mode sharing stimulus, checked every cycle against a queue-level model.
module tb_arb_mux;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [SW-1:0]  sel;
  logic           out_ready;

  logic [N-1:0]   rdy [3];
  logic [W-1:0]   od  [3];
  logic           ov  [3];
  logic [SW-1:0]  og  [3];

  arb_mux #(.WIDTH(W), .N(N), .MODE(0)) u_fixed (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[0]),
    .sel(sel), .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_grant(og[0]));
  arb_mux #(.WIDTH(W), .N(N), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[1]),
    .sel(sel), .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_grant(og[1]));
  arb_mux #(.WIDTH(W), .N(N), .MODE(2)) u_sel (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[2]),
    .sel(sel), .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready), .out_grant(og[2]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // channel chosen by each arbitration rule, -1 when nobody is granted
  function automatic int pick(input int mode, input logic [N-1:0] v, input int s, input int p);
    if (mode == 0) begin
      for (int i = 0; i < N; i++) if (v[i]) return i;
    end else if (mode == 1) begin
      for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    end else begin
      if (s < N && v[s]) return s;
    end
    return -1;
  endfunction

  // model: output slot holds at most one word per mode
  logic         m_vld [3];
  logic [W-1:0] m_dat [3];
  logic [SW-1:0] m_gnt [3];
  int           m_ptr;
  logic         check_en;
  logic [17:0]  sbq[$];
  logic [17:0]  sb_e;

  initial begin
    for (int m = 0; m < 3; m++) begin
      m_vld[m] = 1'b0;
      m_dat[m] = '0;
      m_gnt[m] = '0;
    end
    m_ptr    = 0;
    check_en = 1'b0;
  end

  always @(negedge clk) begin
    int g;
    logic ld;
    logic [N-1:0] er;
    if (check_en) begin
      // round-robin scoreboard on observed DUT handshakes
      if (!rst_n) sbq.delete();
      else begin
        if (ov[1] && out_ready) begin
          chk("sb_depth", 64'(sbq.size()), 64'd1);
          if (sbq.size() != 0) begin
            sb_e = sbq.pop_front();
            chk("sb_word", {og[1], od[1]}, sb_e);
          end
        end
        for (int i = 0; i < N; i++)
          if (rdy[1][i]) sbq.push_back({SW'(i), in_data[i*W +: W]});
      end

      for (int m = 0; m < 3; m++) begin
        ld = !m_vld[m] || out_ready;
        g  = pick(m, in_valid, int'(sel), m_ptr);
        er = '0;
        if (rst_n && ld && g >= 0) er[g] = 1'b1;
        chk($sformatf("m%0d in_ready", m), rdy[m], er);
        chk($sformatf("m%0d onehot0", m), $onehot0(rdy[m]), 1);
        chk($sformatf("m%0d out_valid", m), ov[m], m_vld[m]);
        chk($sformatf("m%0d out_data", m), od[m], m_dat[m]);
        chk($sformatf("m%0d out_grant", m), og[m], m_gnt[m]);
        if (!rst_n) begin
          m_vld[m] = 1'b0;
          m_dat[m] = '0;
          m_gnt[m] = '0;
          if (m == 1) m_ptr = 0;
        end else if (er != '0) begin
          m_vld[m] = 1'b1;
          m_dat[m] = in_data[g*W +: W];
          m_gnt[m] = SW'(g);
          if (m == 1) m_ptr = (g + 1) % N;
        end else if (m_vld[m] && out_ready) begin
          m_vld[m] = 1'b0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    sel       = '0;
    in_data   = {16'hA3, 16'hA2, 16'hA1, 16'hA0};
    cyc();
    cyc();
    check_en = 1'b1;
    @(negedge clk);
    chk("reset out_valid", ov[1], 0);
    chk("reset out_data", od[1], 0);
    chk("reset in_ready", {rdy[0], rdy[1], rdy[2]}, 0);

    // round-robin rotation with all channels valid
    cyc();
    rst_n = 1'b1;
    in_valid = 4'hF;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rr first ready", rdy[1], 4'b0001);
    for (int k = 0; k < 6; k++) begin
      cyc();
      @(negedge clk);
      chk("rr grant seq", og[1], k % 4);
      chk("rr data seq", od[1], W'(16'hA0 + k % 4));
      chk("rr valid", ov[1], 1);
    end

    // stall: slot holds channel 2, then rotation resumes at 3
    cyc();
    out_ready = 1'b0;
    @(negedge clk);
    chk("stall grant", og[1], 2);
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      chk("stall ready", rdy[1], 0);
      chk("stall grant", og[1], 2);
      chk("stall data", od[1], 16'hA2);
      chk("stall valid", ov[1], 1);
    end
    cyc();
    out_ready = 1'b1;
    @(negedge clk);
    chk("release ready", rdy[1], 4'b1000);
    cyc();
    @(negedge clk);
    chk("release grant", og[1], 3);
    chk("release data", od[1], 16'hA3);

    // fixed priority with 1010
    cyc();
    in_valid = 4'b1010;
    @(negedge clk);
    chk("fixed ready", rdy[0], 4'b0010);
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      chk("fixed grant", og[0], 1);
      chk("fixed ready", rdy[0], 4'b0010);
      chk("fixed data", od[0], 16'hA1);
    end

    // direct select
    cyc();
    in_data[2*W +: W] = 16'h1234;
    sel = 2'd2;
    in_valid = 4'b0100;
    @(negedge clk);
    chk("sel ready", rdy[2], 4'b0100);
    cyc();
    @(negedge clk);
    chk("sel data", od[2], 16'h1234);
    chk("sel grant", og[2], 2);
    cyc();
    in_valid = 4'b1011;
    @(negedge clk);
    chk("sel no ready", rdy[2], 0);
    cyc();
    @(negedge clk);
    chk("sel drained", ov[2], 0);

    // reset while holding a word
    cyc();
    in_valid = 4'hF;
    cyc();
    out_ready = 1'b0;
    @(negedge clk);
    chk("pre-reset valid", ov[1], 1);
    cyc();
    rst_n = 1'b0;
    @(negedge clk);
    chk("in reset ready", {rdy[0], rdy[1], rdy[2]}, 0);
    cyc();
    rst_n = 1'b1;
    in_valid = 4'b0110;
    @(negedge clk);
    chk("post-reset valid", ov[1], 0);
    chk("post-reset data", od[1], 0);
    chk("post-reset ready", rdy[1], 4'b0010);
    cyc();
    @(negedge clk);
    chk("post-reset grant", og[1], 1);
    chk("post-reset word", od[1], 16'hA1);

    // random traffic, occasional reset
    for (int k = 0; k < 400; k++) begin
      cyc();
      rst_n     = ($urandom_range(0, 63) != 0);
      in_valid  = N'($urandom);
      in_data   = {$urandom, $urandom};
      sel       = SW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = '0;
    cyc();
    cyc();
    @(negedge clk);
    chk("sb left over", 64'(sbq.size()), 64'(ov[1]));
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
